// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: loads a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per shift_en strobe.
// Latency: first bit is on o_sout the cycle after the accept edge; o_done pulses the cycle after the final slot is consumed.
// Backpressure: o_load_ready is low mid-frame; it rises in IDLE or in the final slot with shift_en, allowing gapless back-to-back frames.
//
// Optional feature macro: PISO_PARITY_EN. When defined, a parity slot (^data ^ PARITY_ODD) follows the data bits.
//
// Ports:
//   i_clk         clock, all state changes on posedge
//   i_rst_n       synchronous active-low reset
//   i_load_valid  producer has a word on i_pdata
//   o_load_ready  word can be accepted this cycle (combinational)
//   i_pdata       parallel word, sampled only on accept
//   i_shift_en    bit-rate strobe; the current bit slot ends on a posedge where it is high
//   o_sout        serial data (registered)
//   o_sout_valid  o_sout carries a frame bit (registered)
//   o_busy        frame in progress (same as o_sout_valid)
//   o_done        one-cycle pulse after a frame's final slot
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   LSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   PARITY_ODD = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_pdata,
  input  logic             i_shift_en,
  output logic             o_sout,
  output logic             o_sout_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_done;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  logic w_final_slot;
  logic w_frame_end;
  logic w_load_ready;
  logic w_accept;
  logic w_first_bit;

`ifdef PISO_PARITY_EN
  assign w_final_slot = (r_state == S_PAR);
`else
  assign w_final_slot = (r_state == S_DATA) && (r_bit_cnt == LAST);
`endif

  // Frame end and a new accept can coincide, giving a gapless next frame.
  assign w_frame_end  = w_final_slot & i_shift_en;
  assign w_load_ready = (r_state == S_IDLE) | w_frame_end;
  assign w_accept     = i_load_valid & w_load_ready;
  assign w_first_bit  = (LSB_FIRST != 0) ? i_pdata[0] : i_pdata[WIDTH-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_sout       <= IDLE_LEVEL;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_done <= w_frame_end;
      if (w_accept) begin
        r_state      <= S_DATA;
        r_shift      <= i_pdata;
        r_bit_cnt    <= '0;
        r_sout       <= w_first_bit;
        r_sout_valid <= 1'b1;
`ifdef PISO_PARITY_EN
        // Parity is taken from the word as loaded, before shifting destroys it.
        r_par        <= (^i_pdata) ^ (PARITY_ODD != 0);
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            // shift_en has no effect while idle
          end
          S_DATA: begin
            if (i_shift_en) begin
              if (r_bit_cnt == LAST) begin
`ifdef PISO_PARITY_EN
                r_state      <= S_PAR;
                r_sout       <= r_par;
`else
                r_state      <= S_IDLE;
                r_sout       <= IDLE_LEVEL;
                r_sout_valid <= 1'b0;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
                // The output end of the shift register always holds the bit on o_sout.
                if (LSB_FIRST != 0) begin
                  r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                  r_sout  <= r_shift[1];
                end else begin
                  r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                  r_sout  <= r_shift[WIDTH-2];
                end
              end
            end
          end
`ifdef PISO_PARITY_EN
          S_PAR: begin
            if (i_shift_en) begin
              r_state      <= S_IDLE;
              r_sout       <= IDLE_LEVEL;
              r_sout_valid <= 1'b0;
            end
          end
`endif
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // The bit already presented at the output end is never re-read from the register;
  // PARITY_ODD is meaningful only in the parity build.
  logic w_unused;
  assign w_unused = ^{r_shift[0], r_shift[WIDTH-1], (PARITY_ODD != 0)};

  assign o_load_ready = w_load_ready;
  assign o_sout       = r_sout;
  assign o_sout_valid = r_sout_valid;
  assign o_busy       = r_sout_valid;
  assign o_done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_lv, a_se, a_lr, a_so, a_sv, a_busy, a_done;
  logic [3:0] a_pd;
  logic       b_lv, b_se, b_lr, b_so, b_sv, b_busy, b_done;
  logic [3:0] b_pd;
  logic       c_lv, c_se, c_lr, c_so, c_sv, c_busy, c_done;
  logic [7:0] c_pd;
  logic       d_lv, d_se, d_lr, d_so, d_sv, d_busy, d_done;
  logic [7:0] d_pd;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];
  bit exp_qd[$];

  piso_serializer #(.WIDTH(4), .LSB_FIRST(0), .IDLE_LEVEL(1'b0), .PARITY_ODD(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(a_lv), .o_load_ready(a_lr), .i_pdata(a_pd),
    .i_shift_en(a_se), .o_sout(a_so), .o_sout_valid(a_sv), .o_busy(a_busy), .o_done(a_done));

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1), .IDLE_LEVEL(1'b0), .PARITY_ODD(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(b_lv), .o_load_ready(b_lr), .i_pdata(b_pd),
    .i_shift_en(b_se), .o_sout(b_so), .o_sout_valid(b_sv), .o_busy(b_busy), .o_done(b_done));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(0), .IDLE_LEVEL(1'b0), .PARITY_ODD(0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(c_lv), .o_load_ready(c_lr), .i_pdata(c_pd),
    .i_shift_en(c_se), .o_sout(c_so), .o_sout_valid(c_sv), .o_busy(c_busy), .o_done(c_done));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(0), .IDLE_LEVEL(1'b0), .PARITY_ODD(1)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(d_lv), .o_load_ready(d_lr), .i_pdata(d_pd),
    .i_shift_en(d_se), .o_sout(d_so), .o_sout_valid(d_sv), .o_busy(d_busy), .o_done(d_done));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_so !== 1'b0 || a_sv !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_lr !== 1'b1) begin
      failures++;
      $display("FAIL reset_a: sout=%b sv=%b busy=%b done=%b lr=%b, want 0 0 0 0 1", a_so, a_sv, a_busy, a_done, a_lr);
    end
    checks++;
    if (b_so !== 1'b0 || b_sv !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_lr !== 1'b1) begin
      failures++;
      $display("FAIL reset_b: sout=%b sv=%b busy=%b done=%b lr=%b, want 0 0 0 0 1", b_so, b_sv, b_busy, b_done, b_lr);
    end
    checks++;
    if (c_so !== 1'b0 || c_sv !== 1'b0 || c_busy !== 1'b0 || c_done !== 1'b0 || c_lr !== 1'b1) begin
      failures++;
      $display("FAIL reset_c: sout=%b sv=%b busy=%b done=%b lr=%b, want 0 0 0 0 1", c_so, c_sv, c_busy, c_done, c_lr);
    end
    // shift_en while idle with no load must leave the serializer idle
    rst_n = 1'b1;
    a_se  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_sv !== 1'b0 || a_so !== 1'b0 || a_done !== 1'b0 || a_lr !== 1'b1) begin
      failures++;
      $display("FAIL idle_shift: sv=%b sout=%b done=%b lr=%b, want 0 0 0 1", a_sv, a_so, a_done, a_lr);
    end
    a_se = 1'b0;
  endtask

  task automatic test_msb_first();
    logic [3:0] w, got;
    bit e;
    w = 4'b1011; got = '0;
    @(negedge clk);
    a_pd = w; a_lv = 1'b1; a_se = 1'b1;
    #1;
    checks++;
    if (a_lr !== 1'b1) begin
      failures++;
      $display("FAIL msb_ready: lr=%b, want 1", a_lr);
    end
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      a_lv = 1'b0; a_pd = '0;
      e = exp_q.pop_front();
      checks++;
      if (a_so !== e || a_sv !== 1'b1 || a_done !== 1'b0) begin
        failures++;
        $display("FAIL msb_bit c=%0d: sout=%b sv=%b done=%b, want %b 1 0", c, a_so, a_sv, a_done, e);
      end
      got = {got[2:0], a_so};
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_so !== 1'b0 || a_sv !== 1'b0) begin
      failures++;
      $display("FAIL msb_end: done=%b sout=%b sv=%b, want 1 0 0", a_done, a_so, a_sv);
    end
    checks++;
    if (got !== w) begin
      failures++;
      $display("FAIL msb_word: got %b, want %b", got, w);
    end
    a_se = 1'b0;
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL msb_done_width: done=%b, want 0", a_done);
    end
  endtask

  task automatic test_lsb_stretch();
    logic [3:0] w, got;
    int k;
    w = 4'b1010; got = '0; k = 0;
    @(negedge clk);
    b_pd = w; b_lv = 1'b1; b_se = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      b_lv = 1'b0; b_pd = '0;
      checks++;
      if (b_so !== exp_q[0] || b_sv !== 1'b1 || b_done !== 1'b0) begin
        failures++;
        $display("FAIL lsb_bit c=%0d: sout=%b sv=%b done=%b, want %b 1 0", c, b_so, b_sv, b_done, exp_q[0]);
      end
      b_se = (c % 3 == 0);
      #1;
      checks++;
      if (b_lr !== (c == 12)) begin
        failures++;
        $display("FAIL lsb_ready c=%0d: lr=%b, want %b", c, b_lr, (c == 12));
      end
      if (b_se) begin
        got[k] = b_so;
        k++;
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    b_se = 1'b0;
    checks++;
    if (b_done !== 1'b1 || b_sv !== 1'b0 || b_so !== 1'b0) begin
      failures++;
      $display("FAIL lsb_end: done=%b sv=%b sout=%b, want 1 0 0", b_done, b_sv, b_so);
    end
    checks++;
    if (got !== w) begin
      failures++;
      $display("FAIL lsb_word: got %b, want %b", got, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w1, w2;
    logic [7:0] got;
    int ndone;
    bit e;
    w1 = 4'b1011; w2 = 4'b1010; got = '0; ndone = 0;
    @(negedge clk);
    a_pd = w1; a_lv = 1'b1; a_se = 1'b1;
    for (int i = 3; i >= 0; i--) exp_q.push_back(w1[i]);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a_pd = w2; a_lv = 1'b1;
        for (int i = 3; i >= 0; i--) exp_q.push_back(w2[i]);
      end
      if (c == 5) a_lv = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (a_so !== e || a_sv !== 1'b1 || a_done !== (c == 5)) begin
        failures++;
        $display("FAIL b2b_bit c=%0d: sout=%b sv=%b done=%b, want %b 1 %b", c, a_so, a_sv, a_done, e, (c == 5));
      end
      got = {got[6:0], a_so};
      if (a_done === 1'b1) ndone++;
    end
    @(negedge clk);
    a_se = 1'b0;
    if (a_done === 1'b1) ndone++;
    checks++;
    if (a_sv !== 1'b0 || ndone != 2) begin
      failures++;
      $display("FAIL b2b_end: sv=%b done_pulses=%0d, want 0 2", a_sv, ndone);
    end
    checks++;
    if (got !== {w1, w2}) begin
      failures++;
      $display("FAIL b2b_word: got %b, want %b", got, {w1, w2});
    end
  endtask

  task automatic test_hold_busy();
    logic [3:0] w, got;
    int k;
    w = 4'b0110; got = '0; k = 3;
    @(negedge clk);
    a_pd = w; a_lv = 1'b1; a_se = 1'b0;
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (a_so !== exp_q[0] || a_sv !== 1'b1) begin
        failures++;
        $display("FAIL hold_bit c=%0d: sout=%b sv=%b, want %b 1", c, a_so, a_sv, exp_q[0]);
      end
      a_lv = (c <= 6);
      a_pd = 4'($urandom);
      a_se = (c % 2 == 0);
      #1;
      checks++;
      if (a_lr !== (c == 8)) begin
        failures++;
        $display("FAIL hold_ready c=%0d: lr=%b, want %b", c, a_lr, (c == 8));
      end
      if (a_se) begin
        got[k] = a_so;
        k--;
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    a_se = 1'b0; a_lv = 1'b0;
    checks++;
    if (a_done !== 1'b1 || a_sv !== 1'b0) begin
      failures++;
      $display("FAIL hold_end: done=%b sv=%b, want 1 0", a_done, a_sv);
    end
    checks++;
    if (got !== w) begin
      failures++;
      $display("FAIL hold_word: got %b, want %b", got, w);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w1, w2, got;
    bit e;
    w1 = 8'hA5; w2 = 8'h3C; got = '0;
    @(negedge clk);
    c_pd = w1; c_lv = 1'b1; c_se = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w1[i]);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      c_lv = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (c_so !== e || c_sv !== 1'b1) begin
        failures++;
        $display("FAIL rst_pre c=%0d: sout=%b sv=%b, want %b 1", c, c_so, c_sv, e);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (c_so !== 1'b0 || c_busy !== 1'b0 || c_sv !== 1'b0 || c_done !== 1'b0 || c_lr !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid: sout=%b busy=%b sv=%b done=%b lr=%b, want 0 0 0 0 1", c_so, c_busy, c_sv, c_done, c_lr);
    end
    exp_q.delete();
    rst_n = 1'b1;
    c_pd = w2; c_lv = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w2[i]);
    if (NPAR == 1) exp_q.push_back(^w2);
    for (int c = 1; c <= 8 + NPAR; c++) begin
      @(negedge clk);
      c_lv = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (c_so !== e || c_sv !== 1'b1 || c_done !== 1'b0) begin
        failures++;
        $display("FAIL rst_post c=%0d: sout=%b sv=%b done=%b, want %b 1 0", c, c_so, c_sv, c_done, e);
      end
      if (c <= 8) got = {got[6:0], c_so};
    end
    @(negedge clk);
    c_se = 1'b0;
    checks++;
    if (c_done !== 1'b1 || c_sv !== 1'b0) begin
      failures++;
      $display("FAIL rst_post_end: done=%b sv=%b, want 1 0", c_done, c_sv);
    end
    checks++;
    if (got !== w2) begin
      failures++;
      $display("FAIL rst_post_word: got %h, want %h", got, w2);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [7:0] w, gotc, gotd;
    bit ec, ed;
    w = 8'h07; gotc = '0; gotd = '0;
    @(negedge clk);
    c_pd = w; c_lv = 1'b1; c_se = 1'b1;
    d_pd = w; d_lv = 1'b1; d_se = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(w[i]);
      exp_qd.push_back(w[i]);
    end
    exp_q.push_back(^w);
    exp_qd.push_back(~(^w));
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      c_lv = 1'b0; d_lv = 1'b0;
      ec = exp_q.pop_front();
      ed = exp_qd.pop_front();
      checks++;
      if (c_so !== ec || d_so !== ed || c_sv !== 1'b1 || d_sv !== 1'b1 || c_done !== 1'b0) begin
        failures++;
        $display("FAIL par_bit c=%0d: even=%b odd=%b sv=%b%b done=%b, want %b %b 11 0", c, c_so, d_so, c_sv, d_sv, c_done, ec, ed);
      end
      if (c <= 8) begin
        gotc = {gotc[6:0], c_so};
        gotd = {gotd[6:0], d_so};
      end
    end
    @(negedge clk);
    c_se = 1'b0; d_se = 1'b0;
    checks++;
    if (c_done !== 1'b1 || d_done !== 1'b1 || c_sv !== 1'b0 || d_sv !== 1'b0) begin
      failures++;
      $display("FAIL par_end: done=%b%b sv=%b%b, want 11 00", c_done, d_done, c_sv, d_sv);
    end
    checks++;
    if (gotc !== w || gotd !== w) begin
      failures++;
      $display("FAIL par_word: got %h %h, want %h", gotc, gotd, w);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    a_lv = 1'b0; a_se = 1'b0; a_pd = '0;
    b_lv = 1'b0; b_se = 1'b0; b_pd = '0;
    c_lv = 1'b0; c_se = 1'b0; c_pd = '0;
    d_lv = 1'b0; d_se = 1'b0; d_pd = '0;
    test_reset();
    test_msb_first();
    test_lsb_stretch();
    test_back_to_back();
    test_hold_busy();
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
